// File: rtl/merge_sort_stream_if.sv
// Stream bundle for merge_sort_stream: producer side (master) and sorter side (slave).
// Optional macro MERGE_SORT_STREAM_IDX_EN adds the out_idx arrival-position tag.
interface merge_sort_stream_if #(
  parameter int DW = 8,
  parameter int N  = 8
);
  localparam int IW = $clog2(N);

  logic          mode_desc;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef MERGE_SORT_STREAM_IDX_EN
  logic [IW-1:0] out_idx;

  modport master (
    output mode_desc, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, out_idx
  );
  modport slave (
    input  mode_desc, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, out_idx
  );
`else
  modport master (
    output mode_desc, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
  modport slave (
    input  mode_desc, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
`endif
endinterface

// File: rtl/merge_sort_stream.sv
// Bottom-up merge sorter: load N words, merge in ping-pong buffers, stream the sorted frame out.
// Optional macro MERGE_SORT_STREAM_IDX_EN carries each word's arrival index through the sort.
module merge_sort_stream #(
  parameter int DW = 8,
  parameter int N  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  merge_sort_stream_if.slave   stream
);
  localparam int              IW    = $clog2(N);
  localparam logic [IW-1:0]   LAST  = IW'(N - 1);
  localparam logic [IW:0]     HALF  = (IW + 1)'(N / 2);
  localparam logic [IW:0]     ONE_W = (IW + 1)'(1);
  localparam logic [IW-1:0]   ONE_I = IW'(1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] buf0 [N];
  logic [DW-1:0] buf1 [N];

  logic [IW-1:0] wr_cnt, rd_cnt, l, k;
  logic [IW:0]   width, i, j;
  logic          src_sel, desc;
  logic          out_valid_q, out_last_q;
  logic [DW-1:0] out_data_q;

  logic          load_fire, out_fire;
  logic [IW-1:0] left_idx, right_idx;
  logic [DW-1:0] left_val, right_val, sel_val, drain_val;
  logic          left_ok, right_ok, take_left, run_done, pass_done, last_pass;

`ifdef MERGE_SORT_STREAM_IDX_EN
  logic [IW-1:0] tag0 [N];
  logic [IW-1:0] tag1 [N];
  logic [IW-1:0] left_tag, right_tag, sel_tag, drain_tag, out_idx_q;
`endif

  assign load_fire = (state == LOAD) && stream.in_valid;
  assign out_fire  = out_valid_q && stream.out_ready;

  // Merge step: left run is src[l..l+width-1], right run follows it.
  always_comb begin
    left_idx  = l + IW'(i);
    right_idx = l + IW'(width) + IW'(j);
    left_val  = src_sel ? buf1[left_idx]  : buf0[left_idx];
    right_val = src_sel ? buf1[right_idx] : buf0[right_idx];
    drain_val = src_sel ? buf1[rd_cnt]    : buf0[rd_cnt];
    left_ok   = i < width;
    right_ok  = j < width;
    // Ties go left so equal keys keep arrival order.
    take_left = left_ok && (!right_ok ||
                (desc ? (left_val >= right_val) : (left_val <= right_val)));
    sel_val   = take_left ? left_val : right_val;
    run_done  = (i + j + ONE_W) == (width << 1);
    pass_done = k == LAST;
    last_pass = width == HALF;
  end

`ifdef MERGE_SORT_STREAM_IDX_EN
  always_comb begin
    left_tag  = src_sel ? tag1[left_idx]  : tag0[left_idx];
    right_tag = src_sel ? tag1[right_idx] : tag0[right_idx];
    drain_tag = src_sel ? tag1[rd_cnt]    : tag0[rd_cnt];
    sel_tag   = take_left ? left_tag : right_tag;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (load_fire && wr_cnt == LAST)  state_nxt = SORT;
      SORT:    if (pass_done && last_pass)       state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_last_q)       state_nxt = LOAD;
      default:                                   state_nxt = LOAD;
    endcase
  end

  // NOTE: the buffers are never reset; stale contents are always overwritten before being read.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      buf0[wr_cnt] <= stream.in_data;
`ifdef MERGE_SORT_STREAM_IDX_EN
      tag0[wr_cnt] <= wr_cnt;
`endif
    end else if (state == SORT) begin
      if (src_sel) buf0[k] <= sel_val;
      else         buf1[k] <= sel_val;
`ifdef MERGE_SORT_STREAM_IDX_EN
      if (src_sel) tag0[k] <= sel_tag;
      else         tag1[k] <= sel_tag;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      l           <= '0;
      k           <= '0;
      width       <= '0;
      i           <= '0;
      j           <= '0;
      src_sel     <= 1'b0;
      desc        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef MERGE_SORT_STREAM_IDX_EN
      out_idx_q   <= '0;
`endif
    end else begin
      unique case (state)
        LOAD: if (load_fire) begin
          if (wr_cnt == '0) desc <= stream.mode_desc;
          wr_cnt <= wr_cnt + ONE_I;
          if (wr_cnt == LAST) begin
            wr_cnt  <= '0;
            width   <= ONE_W;
            l       <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            src_sel <= 1'b0;
          end
        end
        SORT: begin
          k <= k + ONE_I;
          if (take_left) i <= i + ONE_W;
          else           j <= j + ONE_W;
          if (run_done) begin
            l <= l + IW'(width << 1);
            i <= '0;
            j <= '0;
          end
          if (pass_done) begin
            src_sel <= ~src_sel;
            width   <= width << 1;
            l       <= '0;
            k       <= '0;
          end
        end
        DRAIN: begin
          // rd_cnt indexes the next word to move into the output register.
          if (!out_valid_q || (out_fire && !out_last_q)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= drain_val;
            out_last_q  <= rd_cnt == LAST;
            rd_cnt      <= rd_cnt + ONE_I;
`ifdef MERGE_SORT_STREAM_IDX_EN
            out_idx_q   <= drain_tag;
`endif
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            rd_cnt      <= '0;
`ifdef MERGE_SORT_STREAM_IDX_EN
            out_idx_q   <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign stream.in_ready  = state == LOAD;
  assign stream.busy      = state != LOAD;
  assign stream.out_valid = out_valid_q;
  assign stream.out_data  = out_data_q;
  assign stream.out_last  = out_last_q;
`ifdef MERGE_SORT_STREAM_IDX_EN
  assign stream.out_idx   = out_idx_q;
`endif

endmodule

// File: tb/tb_merge_sort_stream.sv
// Self-checking bench: an N=8/DW=8 and an N=16/DW=16 sorter driven from a frame table with a scoreboard.
module tb_merge_sort_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          cur_sel;
  logic        tb_in_valid, tb_mode, tb_out_ready;
  logic [15:0] tb_in_data;

  merge_sort_stream_if #(.DW(8),  .N(8))  a_if ();
  merge_sort_stream_if #(.DW(16), .N(16)) b_if ();

  merge_sort_stream #(.DW(8),  .N(8))  u_a (.clk(clk), .rst_n(rst_n), .stream(a_if));
  merge_sort_stream #(.DW(16), .N(16)) u_b (.clk(clk), .rst_n(rst_n), .stream(b_if));

  assign a_if.in_valid  = (cur_sel == 0) && tb_in_valid;
  assign a_if.in_data   = tb_in_data[7:0];
  assign a_if.mode_desc = tb_mode;
  assign a_if.out_ready = (cur_sel == 0) && tb_out_ready;
  assign b_if.in_valid  = (cur_sel != 0) && tb_in_valid;
  assign b_if.in_data   = tb_in_data;
  assign b_if.mode_desc = tb_mode;
  assign b_if.out_ready = (cur_sel != 0) && tb_out_ready;

  logic        obs_out_valid, obs_out_last, obs_in_ready, obs_busy;
  logic [15:0] obs_out_data;
  logic [3:0]  obs_idx;
  assign obs_out_valid = (cur_sel != 0) ? b_if.out_valid : a_if.out_valid;
  assign obs_out_last  = (cur_sel != 0) ? b_if.out_last  : a_if.out_last;
  assign obs_in_ready  = (cur_sel != 0) ? b_if.in_ready  : a_if.in_ready;
  assign obs_busy      = (cur_sel != 0) ? b_if.busy      : a_if.busy;
  assign obs_out_data  = (cur_sel != 0) ? b_if.out_data  : {8'h00, a_if.out_data};
`ifdef MERGE_SORT_STREAM_IDX_EN
  assign obs_idx       = (cur_sel != 0) ? b_if.out_idx   : {1'b0, a_if.out_idx};
`else
  assign obs_idx       = 4'd0;
`endif

  typedef int arr16_t [16];
  typedef struct {
    int                sel;
    int                len;
    logic              desc;
    logic              toggle;
    int                bp;
    logic              pre_reset;
    logic [15:0][15:0] din;
    logic [15:0][15:0] dexp;
    logic [15:0][3:0]  iexp;
  } vec_t;
  typedef struct {
    logic [15:0] d;
    logic        last;
    logic [3:0]  idx;
  } exp_t;

  exp_t   sb[$];
  vec_t   vecs[7];
  int     checks = 0;
  int     errors = 0;
  int     bp_pat[6] = '{1, 0, 0, 1, 0, 1};

  arr16_t v0_in  = '{5, 3, 8, 1, 7, 2, 6, 4, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v0_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v0_idx = '{3, 5, 1, 7, 0, 6, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v1_exp = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v1_idx = '{2, 4, 6, 0, 7, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v2_in  = '{3, 1, 3, 1, 2, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v2_exp = '{0, 1, 1, 2, 2, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v2_idx = '{6, 1, 3, 4, 5, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v3_in  = '{255, 0, 128, 127, 1, 254, 16, 16, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v3_exp = '{0, 1, 16, 16, 127, 128, 254, 255, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t v3_idx = '{1, 4, 6, 7, 3, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  arr16_t ramp, ramp_rev, iota, iota_rev, flat;

  function automatic vec_t mk(int sel, int len, logic desc, logic toggle, int bp,
                              logic pre_reset, arr16_t din, arr16_t dexp, arr16_t iexp);
    vec_t v;
    v.sel = sel; v.len = len; v.desc = desc; v.toggle = toggle;
    v.bp = bp; v.pre_reset = pre_reset;
    for (int w = 0; w < 16; w++) begin
      v.din[w]  = 16'(din[w]);
      v.dexp[w] = 16'(dexp[w]);
      v.iexp[w] = 4'(iexp[w]);
    end
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int f);
    int   bud, lat, got, flag_err, hold_err, lg;
    logic rdy, r, stall, held_l;
    logic [15:0] held_d;
    logic [3:0]  held_i;
    exp_t e;
    cur_sel = v.sel;
    lg = 0;
    while ((1 << lg) < v.len) lg++;
    for (int w = 0; w < v.len; w++) begin
      tb_in_valid = 1'b1;
      tb_in_data  = v.din[w];
      tb_mode     = (w == 0 || !v.toggle) ? v.desc : ~v.desc;
      e.d = v.dexp[w]; e.last = (w == v.len - 1); e.idx = v.iexp[w];
      sb.push_back(e);
      bud = 0;
      do begin
        rdy = obs_in_ready;
        @(posedge clk); #1;
        bud++;
      end while (!rdy && bud < 100);
      check($sformatf("f%0d_load_accept_%0d", f, w), rdy, 1);
    end
    // Junk on the input while sorting must be ignored.
    tb_in_valid = 1'b1;
    tb_in_data  = 16'hEEEE;
    lat = 0; flag_err = 0;
    while (!obs_out_valid && lat < 200) begin
      if (obs_in_ready || !obs_busy) flag_err++;
      @(posedge clk); #1;
      lat++;
    end
    tb_in_valid = 1'b0;
    check($sformatf("f%0d_latency", f), lat, v.len * lg + 1);

    got = 0; bud = 0; stall = 1'b0; hold_err = 0;
    held_d = '0; held_l = 1'b0; held_i = '0;
    while (got < v.len && bud < 2000) begin
      if (stall && (!obs_out_valid || obs_out_data !== held_d ||
                    obs_out_last !== held_l || obs_idx !== held_i)) hold_err++;
      if (obs_out_valid && (obs_in_ready || !obs_busy)) flag_err++;
      case (v.bp)
        0:       r = 1'b1;
        1:       r = bp_pat[bud % 6] != 0;
        default: r = $urandom_range(0, 1) != 0;
      endcase
      tb_out_ready = r;
      stall  = obs_out_valid && !r;
      held_d = obs_out_data; held_l = obs_out_last; held_i = obs_idx;
      if (obs_out_valid && r) begin
        check($sformatf("f%0d_sb_nonempty_%0d", f, got), sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check($sformatf("f%0d_data_%0d", f, got), obs_out_data, e.d);
          check($sformatf("f%0d_last_%0d", f, got), obs_out_last, e.last);
`ifdef MERGE_SORT_STREAM_IDX_EN
          check($sformatf("f%0d_idx_%0d", f, got), obs_idx, e.idx);
`endif
        end
        got++;
      end
      @(posedge clk); #1;
      bud++;
    end
    tb_out_ready = 1'b0;
    check($sformatf("f%0d_word_count", f), got, v.len);
    check($sformatf("f%0d_sb_drained", f), sb.size(), 0);
    check($sformatf("f%0d_stall_hold", f), hold_err, 0);
    check($sformatf("f%0d_ready_busy", f), flag_err, 0);
    check($sformatf("f%0d_idle_valid", f), obs_out_valid, 0);
    check($sformatf("f%0d_idle_ready", f), obs_in_ready, 1);
    check($sformatf("f%0d_idle_busy", f), obs_busy, 0);
  endtask

  task automatic reset_mid_sort();
    int flag;
    cur_sel = 0;
    tb_mode = 1'b0;
    for (int w = 0; w < 8; w++) begin
      tb_in_valid = 1'b1;
      tb_in_data  = 16'(w * 17);
      @(posedge clk); #1;
    end
    tb_in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("midsort_busy", obs_busy, 1);
    check("midsort_in_ready", obs_in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", obs_out_valid, 0);
    check("midreset_in_ready", obs_in_ready, 1);
    check("midreset_busy", obs_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (obs_out_valid || !obs_in_ready) flag++;
    end
    check("post_reset_quiet", flag, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 16; w++) begin
      ramp[w]     = w * 16'h1111;
      ramp_rev[w] = (15 - w) * 16'h1111;
      iota[w]     = w;
      iota_rev[w] = 15 - w;
      flat[w]     = 16'hABCD;
    end
    vecs[0] = mk(0, 8,  1'b0, 1'b0, 0, 1'b0, v0_in, v0_exp, v0_idx);
    vecs[1] = mk(0, 8,  1'b1, 1'b1, 0, 1'b0, v0_in, v1_exp, v1_idx);
    vecs[2] = mk(0, 8,  1'b0, 1'b0, 2, 1'b0, v2_in, v2_exp, v2_idx);
    vecs[3] = mk(0, 8,  1'b0, 1'b0, 1, 1'b1, v3_in, v3_exp, v3_idx);
    vecs[4] = mk(1, 16, 1'b0, 1'b0, 0, 1'b0, ramp,  ramp,   iota);
    vecs[5] = mk(1, 16, 1'b1, 1'b0, 1, 1'b0, flat,  flat,   iota);
    vecs[6] = mk(1, 16, 1'b1, 1'b0, 2, 1'b0, ramp,  ramp_rev, iota_rev);

    cur_sel = 0; tb_in_valid = 1'b0; tb_in_data = '0; tb_mode = 1'b0; tb_out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", obs_out_valid, 0);
    check("reset_in_ready", obs_in_ready, 1);
    check("reset_busy", obs_busy, 0);
    check("reset_out_last", obs_out_last, 0);
    check("reset_out_data", obs_out_data, 0);
    check("reset_out_idx", obs_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int f = 0; f < 7; f++) begin
      if (vecs[f].pre_reset) reset_mid_sort();
      run_frame(vecs[f], f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/merge_sort_stream.md
Name: merge_sort_stream

Overview:
- Sequential, parametrised bottom-up merge sorter with valid/ready streaming ports.
- Accepts a frame of exactly N words, sorts them in internal ping-pong buffers, then streams the sorted frame out.
- Successor to the combinational array sorter. Adds configurable width and depth, selectable ascending/descending order, stable ordering, backpressure and a single-clock pipeline position between a producer and a consumer stream.

Parameters:
DW, 8, data word width in bits (>=1)
N, 8, frame depth in words; power of two, >=2
IW, $clog2(N), derived local parameter; index/counter width, not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode_desc  in  1  sort order: 0 ascending, 1 descending; sampled on first accepted input word of a frame
in_valid  in  1  input word valid
in_ready  out  1  block can accept input word
in_data  in  DW  input word, unsigned
out_valid  out  1  sorted word valid
out_ready  in  1  consumer accepts sorted word
out_data  out  DW  sorted word
out_last  out  1  marks Nth (final) word of sorted frame
busy  out  1  high in SORT and DRAIN states

Behaviour:
- Reset (async assert, sync release): state=LOAD, all counters 0, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0. Buffer contents are don't-care.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready handshake writes in_data to buf0[wr_cnt] and increments wr_cnt.
  - mode_desc is latched on the handshake with wr_cnt==0.
  - On the handshake with wr_cnt==N-1: in_ready drops the next cycle, state goes to SORT, and width=1, l=0, i=0, j=0, k=0.
- SORT:
  - in_ready=0, busy=1.
  - Passes width=1,2,4..N/2, log2(N) passes total.
  - Each cycle writes exactly one element of the destination buffer at index k, merging left run src[l..l+width-1] with right run src[l+width..l+2*width-1].
  - Selection while both runs are non-empty:
    - Ascending: take left if L<=R.
    - Descending: take left if L>=R.
    - Ties always take left, so the sort is stable.
  - Once one run is exhausted, copy the other.
  - After 2*width writes, advance l by 2*width and reset i and j.
  - After N writes, swap src/dst, double width, l=0, k=0.
  - Each pass takes exactly N cycles; SORT lasts N*log2(N) cycles.
- DRAIN:
  - Entered the cycle after the final SORT write. out_valid=1 with out_data=final_buf[rd_cnt]. out_last=1 when rd_cnt==N-1.
  - out_valid&&out_ready advances rd_cnt.
  - While out_valid&&!out_ready, out_data and out_last are held stable.
  - The handshake with out_last=1 returns the block to LOAD next cycle: out_valid=0, in_ready=1, busy=0.
- Latency: first out_valid occurs N*log2(N)+1 cycles after the clock edge that accepted the last input word. N=8 gives 25 cycles.
- No overlap: the next frame is not accepted until the current frame fully drains.
- Mid-operation reset: rst_n low in any state immediately forces the reset values. The partial frame is discarded, and no partial output follows reset release.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- Comparisons are unsigned and DW bits wide. No data width changes inside the block.

Optional Feature:
MERGE_SORT_STREAM_IDX_EN
- Defined:
  - Adds output port out_idx [IW-1:0] carrying each sorted word's original arrival position (0..N-1).
  - Tags are stored alongside data and move with it through every pass. Comparison uses data only.
  - out_idx is reset to 0 and held stable under backpressure like out_data.
- Undefined: port and tag storage are absent; all other behaviour is identical.

Test Plan:
- Ascending, N=8, DW=8: load 5,3,8,1,7,2,6,4 with mode_desc=0 -> out 1,2,3,4,5,6,7,8; out_last only on 8; first out_valid 25 cycles after last input.
- Descending: same frame with mode_desc=1 -> out 8,7,6,5,4,3,2,1; toggling mode_desc after the first word has no effect.
- Stability (IDX_EN): load 3,1,3,1,2,2,0,3 ascending -> data 0,1,1,2,2,3,3,3 with out_idx 6,1,3,4,5,0,2,7.
- Backpressure: out_ready pattern 1,0,0,1,0,1... -> out_data/out_last constant through stalls, no word lost or duplicated, busy=1 until the last handshake; in_ready=0 throughout SORT/DRAIN.
- Reset mid-sort: assert rst_n=0 ten cycles into SORT -> out_valid=0 and in_ready=1 immediately. A fresh frame 0xFF,0x00,... then sorts correctly with no stale data.
- N=16, DW=16, back-to-back frames: already-sorted frame, then all-equal 0xABCD frame -> first output equals input order; second output is 16×0xABCD. SORT lasts 64 cycles each frame.
